i_mem_refill_ctrl: RTL
======================

// Module: i_mem_refill_ctrl
// PURPOSE
//  Line-refill engine directly downstream of the instruction cache's miss port.
//  - Accepts one line-fill request at a time and issues back-to-back word reads to the instruction memory.
//  - Assembles the returned words into a full cache line and returns it to the cache as a single-cycle response.
//  - Supports a flush that abandons an in-progress refill (branch redirect).
// PARAMETERS
//  LINE_WORDS   4   32-bit words per cache line (power of 2, >=2)
//  MEM_LATENCY  1   fixed instruction-memory read latency in cycles (1..4)
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              synchronous active-high reset
//  flush        in   1              abandon current refill
//  req_valid    in   1              line-fill request from cache
//  req_addr     in   32             miss byte address; offset bits ignored
//  req_ready    out  1              engine idle, request accepted this cycle
//  mem_rd_en    out  1              read strobe to instruction memory
//  mem_addr     out  32             word-aligned byte address of read
//  mem_rd_data  in   32             read data, valid MEM_LATENCY cycles after strobe
//  rsp_valid    out  1              1-cycle pulse: line ready
//  rsp_addr     out  32             line-aligned byte address of returned line
//  rsp_data     out  32*LINE_WORDS  line data; word i at [32*i +: 32]
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, all counters=0, in-flight valid pipe cleared.
//   Outputs after reset: req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_addr=0, rsp_data=0.
//  Reset has priority over flush and req_valid; reset mid-refill drops everything, no rsp.
//  OFF = log2(LINE_WORDS)+2 bits. Base = {req_addr[31:OFF], OFF'b0}, latched on accept.
//  FSM states:
//   IDLE - req_ready=1. req_valid=1 -> latch base, issue_cnt=0, ret_cnt=0 -> ISSUE.
//   ISSUE - mem_rd_en=1; mem_addr=base+4*issue_cnt; issue_cnt++.
//           After the LINE_WORDS-th strobe -> DRAIN.
//   DRAIN - mem_rd_en=0. Wait for ret_cnt==LINE_WORDS -> RESP.
//   RESP - rsp_valid=1 for exactly this cycle; rsp_addr=base; rsp_data = assembled line -> IDLE.
//  Return path: shift pipe of MEM_LATENCY valid bits tracks strobes.
//   When a pipe bit exits, mem_rd_data is written to line word ret_cnt, then ret_cnt++.
//   Words are returned in issue order.
//  Latency: request accepted at edge T -> strobes in cycles T+1..T+LINE_WORDS -> rsp_valid in cycle T+LINE_WORDS+MEM_LATENCY+1.
//   Defaults: 6 cycles.
//  req_ready is 0 in ISSUE/DRAIN/RESP; req_valid there is ignored (no queueing).
//   Back-to-back: IDLE follows RESP, so the earliest next accept is the cycle after rsp_valid.
//  rsp_data/rsp_addr hold their last values while rsp_valid=0.
//  flush=1 (non-IDLE state) -> next state IDLE; valid pipe cleared; no rsp_valid for that line.
//   mem_rd_en drops the following cycle. Late memory data is ignored.
//   flush in IDLE has no effect.
//   flush together with req_valid in IDLE: flush wins, request not accepted, req_ready=0 that cycle.
//   flush in the RESP cycle: rsp_valid still pulses (line complete).
//  Counters are log2(LINE_WORDS)+1 bits; no wrap within a line.
//   The address does not carry across line boundaries (offset only).
//  A request at 0xFFFFFFF0 fetches 0xFFFFFFF0..FC (no overflow).
// TESTING
//  1 Reset: rst=1 2 cycles -> req_ready=1, rsp_valid=0, mem_rd_en=0, rsp_data=0.
//  2 Basic fill: req_addr=0x0000_1234, mem returns addr^0xA5A5A5A5 ->
//    strobes 0x1230,34,38,3C on T+1..T+4; rsp_valid at T+6;
//    rsp_addr=0x1230; word2=0x1238^0xA5A5A5A5.
//  3 Busy: hold req_valid=1 throughout -> second accept in the cycle after rsp_valid;
//    exactly one rsp per accepted request.
//  4 Flush: flush at T+3 -> mem_rd_en=0 from T+4, no rsp_valid;
//    a new request at 0x2000 returns only 0x2000-line data.
//  5 Latency: MEM_LATENCY=3, LINE_WORDS=8, req 0x40 -> rsp_valid at T+12, words in order.
//  6 Edges: req 0xFFFF_FFF4 -> strobes 0xFFFFFFF0..FC; rst mid-DRAIN -> no rsp, req_ready=1.

Source files
------------

// File: rtl/i_mem_refill_ctrl.sv
// Instruction-cache line refill engine: issues back-to-back word reads to the
// instruction memory, assembles the returned words and hands back a full line.
module i_mem_refill_ctrl #(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  input  logic [31:0]               req_addr,
  output logic                      req_ready,
  output logic                      mem_rd_en,
  output logic [31:0]               mem_addr,
  input  logic [31:0]               mem_rd_data,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_addr,
  output logic [32*LINE_WORDS-1:0]  rsp_data
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF   = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                   state_r;
  logic [31:0]              base_r;
  logic [CNT_W-1:0]         issue_cnt_r;
  logic [CNT_W-1:0]         ret_cnt_r;
  logic [MEM_LATENCY-1:0]   pipe_r;
  logic [32*LINE_WORDS-1:0] line_r;
  logic                     req_ready_r;
  logic                     mem_rd_en_r;
  logic [31:0]              mem_addr_r;
  logic                     rsp_valid_r;
  logic [31:0]              rsp_addr_r;
  logic [32*LINE_WORDS-1:0] rsp_data_r;

  logic [MEM_LATENCY:0]     pipe_nxt_s;
  logic [32*LINE_WORDS-1:0] line_nxt_s;
  logic [31:0]              line_base_s;
  logic                     ret_fire_s;
  logic                     last_word_s;
  logic                     accept_s;
  logic                     abort_s;

  // Return tracking, line assembly and request decode.
  always_comb begin
    pipe_nxt_s  = {pipe_r, mem_rd_en_r};
    line_base_s = req_addr & {{(32-OFF){1'b1}}, {OFF{1'b0}}};
    line_nxt_s  = line_r;
    // The oldest strobe leaves the pipe exactly when its data is on mem_rd_data.
    if ((state_r == ISSUE) || (state_r == DRAIN)) begin
      ret_fire_s = pipe_nxt_s[MEM_LATENCY];
    end else begin
      ret_fire_s = 1'b0;
    end
    if (ret_fire_s) begin
      line_nxt_s[{ret_cnt_r[IDX_W-1:0], 5'd0} +: 32] = mem_rd_data;
      last_word_s = (ret_cnt_r == CNT_W'(LINE_WORDS - 1));
    end else begin
      last_word_s = 1'b0;
    end
    if ((state_r == IDLE) && req_valid && !flush) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_r != IDLE) && flush) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Refill FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      base_r      <= 32'd0;
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
      pipe_r      <= '0;
      line_r      <= '0;
      req_ready_r <= 1'b1;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_addr_r  <= 32'd0;
      rsp_data_r  <= '0;
    end else begin
      line_r      <= line_nxt_s;
      rsp_valid_r <= 1'b0;
      if (abort_s) begin
        pipe_r <= '0;
      end else begin
        pipe_r <= pipe_nxt_s[MEM_LATENCY-1:0];
      end
      if (ret_fire_s) begin
        ret_cnt_r <= ret_cnt_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            base_r      <= line_base_s;
            mem_addr_r  <= line_base_s;
            mem_rd_en_r <= 1'b1;
            issue_cnt_r <= CNT_W'(1);
            ret_cnt_r   <= '0;
            req_ready_r <= 1'b0;
            state_r     <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort_s) begin
            mem_rd_en_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else if (issue_cnt_r == CNT_W'(LINE_WORDS)) begin
            mem_rd_en_r <= 1'b0;
            state_r     <= DRAIN;
          end else begin
            // Offset bits only: the fetch never carries into the next line.
            mem_addr_r  <= base_r | {{(32-OFF){1'b0}}, issue_cnt_r[IDX_W-1:0], 2'b00};
            issue_cnt_r <= issue_cnt_r + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (abort_s) begin
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else if (last_word_s) begin
            rsp_valid_r <= 1'b1;
            rsp_addr_r  <= base_r;
            rsp_data_r  <= line_nxt_s;
            state_r     <= RESP;
          end
        end
        RESP: begin
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          mem_rd_en_r <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // A flush in the same cycle as a request overrides the idle handshake.
  assign req_ready = req_ready_r & ~flush;
  assign mem_rd_en = mem_rd_en_r;
  assign mem_addr  = mem_addr_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_addr  = rsp_addr_r;
  assign rsp_data  = rsp_data_r;

endmodule
